regfile_2r1w: RTL and testbench

- Two-read/one-write general-purpose register file that supplies operand buses a and b to the bitwise logic units (nandgate and siblings) of the teaching CPU core.
- Reads are registered, so operands are presented one cycle after address sample, aligned to the execute stage.
- Register 0 is hardwired to zero.
- Write-first bypass: a read of the address being written in the same cycle returns the new data.

---
 rtl/regfile_2r1w.sv | 91 +++++++++
 tb/tb_regfile_2r1w.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_2r1w.sv
// regfile_2r1w
// Two-read/one-write general-purpose register file feeding the operand
// buses (a = rdata1, b = rdata2) of the teaching CPU's bitwise logic units.
// Both read ports are registered, so operands appear one cycle after the
// address is sampled. Register 0 is hardwired to zero. A read of the
// address being written in the same cycle returns the new write data.
//
// Ports
//   clk     in   1       system clock, rising edge
//   rst     in   1       asynchronous active-high reset
//   we      in   1       write enable
//   waddr   in   ADDR_W  write address
//   wdata   in   WIDTH   write data
//   re1     in   1       read port 1 enable (rdata1 holds when low)
//   raddr1  in   ADDR_W  read port 1 address
//   rdata1  out  WIDTH   registered read data, port 1
//   re2     in   1       read port 2 enable (rdata2 holds when low)
//   raddr2  in   ADDR_W  read port 2 address
//   rdata2  out  WIDTH   registered read data, port 2

module regfile_2r1w #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [WIDTH-1:0]  rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [WIDTH-1:0]  rdata2
);

    // Flop storage: every entry must clear on reset, which rules out RAM.
    logic [WIDTH-1:0] regs [DEPTH];

    logic             wr_hit;
    logic [WIDTH-1:0] rd1_next;
    logic [WIDTH-1:0] rd2_next;

    assign wr_hit = we && (waddr != '0);

    // Read-side muxing: r0 always reads zero (and is never bypassed, since
    // a write to r0 is dropped), otherwise a same-cycle write wins over the
    // stored value.
    always_comb begin
        rd1_next = regs[raddr1];
        if (raddr1 == '0) begin
            rd1_next = '0;
        end else if (wr_hit && (waddr == raddr1)) begin
            rd1_next = wdata;
        end

        rd2_next = regs[raddr2];
        if (raddr2 == '0) begin
            rd2_next = '0;
        end else if (wr_hit && (waddr == raddr2)) begin
            rd2_next = wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_hit) begin
            regs[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata1 <= '0;
            rdata2 <= '0;
        end else begin
            if (re1) begin
                rdata1 <= rd1_next;
            end
            if (re2) begin
                rdata2 <= rd2_next;
            end
        end
    end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Testbench for regfile_2r1w: directed scenarios with literal expectations
// followed by randomized traffic, all checked every cycle against a
// behavioural model (array of registers, write applied before read).

module tb_regfile_2r1w;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;

    int vectors;
    int miscompares;
    bit chk_en;

    logic [31:0] m_regs [32];
    logic [31:0] m_rd1;
    logic [31:0] m_rd2;

    regfile_2r1w #(.WIDTH(32), .DEPTH(32), .ADDR_W(5)) dut (
        .clk    (clk),
        .rst    (rst),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .re1    (re1),
        .raddr1 (raddr1),
        .rdata1 (rdata1),
        .re2    (re2),
        .raddr2 (raddr2),
        .rdata2 (rdata2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the register file is an array; a write lands first, then the
    // enabled ports read the updated array (r0 is never written).
    always @(posedge rst) begin
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_rd1 = '0;
        m_rd2 = '0;
    end

    always @(posedge clk) begin
        if (!rst) begin
            if (we && waddr != 0) m_regs[waddr] = wdata;
            if (re1) m_rd1 = (raddr1 == 0) ? 32'h0 : m_regs[raddr1];
            if (re2) m_rd2 = (raddr2 == 0) ? 32'h0 : m_regs[raddr2];
        end
        #1;
        if (chk_en) begin
            check("model_rdata1", rdata1, m_rd1);
            check("model_rdata2", rdata2, m_rd2);
        end
    end

    // Drive one cycle of inputs just after a falling edge and wait for the
    // next falling edge, by which time the rising edge has registered them.
    task automatic step(input logic w, input logic [4:0] wa, input logic [31:0] wd,
                        input logic r1, input logic [4:0] a1,
                        input logic r2, input logic [4:0] a2);
        we = w; waddr = wa; wdata = wd;
        re1 = r1; raddr1 = a1;
        re2 = r2; raddr2 = a2;
        @(negedge clk);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        chk_en = 1'b0;
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_rd1 = '0;
        m_rd2 = '0;
        rst = 1'b1;
        we = 0; waddr = 0; wdata = 0;
        re1 = 0; raddr1 = 0; re2 = 0; raddr2 = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        check("reset_rdata1", rdata1, 32'h0);
        check("reset_rdata2", rdata2, 32'h0);

        // Reset between edges clears storage and outputs immediately
        step(1, 5, 32'hdeadbeef, 0, 0, 0, 0);
        step(0, 0, 0, 1, 5, 1, 5);
        check("pre_reset_r5_p1", rdata1, 32'hdeadbeef);
        check("pre_reset_r5_p2", rdata2, 32'hdeadbeef);
        #1 rst = 1'b1;
        #1;
        check("async_rst_rdata1", rdata1, 32'h0);
        check("async_rst_rdata2", rdata2, 32'h0);
        #2 rst = 1'b0;
        @(negedge clk);
        check("post_reset_r5_p1", rdata1, 32'h0);
        check("post_reset_r5_p2", rdata2, 32'h0);

        // Basic write then read
        step(1, 1, 32'hffffffff, 0, 0, 0, 0);
        step(1, 2, 32'h007fa509, 0, 0, 0, 0);
        step(0, 0, 0, 1, 1, 1, 2);
        check("basic_r1", rdata1, 32'hffffffff);
        check("basic_r2", rdata2, 32'h007fa509);

        // Zero register: writes dropped, no bypass
        step(1, 0, 32'h12345678, 1, 0, 0, 0);
        check("r0_same_cycle", rdata1, 32'h0);
        step(0, 0, 0, 1, 0, 0, 0);
        check("r0_after_write", rdata1, 32'h0);

        // Write-first bypass on both ports
        step(1, 3, 32'ha5a5a5a5, 1, 3, 1, 3);
        check("bypass_p1", rdata1, 32'ha5a5a5a5);
        check("bypass_p2", rdata2, 32'ha5a5a5a5);

        // Read-enable hold
        step(1, 4, 32'h11111111, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 4);
        check("hold_initial", rdata2, 32'h11111111);
        step(1, 4, 32'h22222222, 0, 0, 0, 4);
        check("hold_during_write", rdata2, 32'h11111111);
        step(0, 0, 0, 0, 0, 1, 4);
        check("hold_released", rdata2, 32'h22222222);

        // Sweep all registers, reading pairs (i, 31-i), plus the NAND operand use
        for (int i = 1; i < 32; i++) begin
            step(1, 5'(i), 32'(i) * 32'h01010101, 0, 0, 0, 0);
        end
        for (int i = 0; i < 32; i++) begin
            logic [31:0] e1, e2;
            e1 = 32'(i) * 32'h01010101;
            e2 = 32'(31 - i) * 32'h01010101;
            step(0, 0, 0, 1, 5'(i), 1, 5'(31 - i));
            check("sweep_p1", rdata1, e1);
            check("sweep_p2", rdata2, e2);
            check("sweep_nand", ~(rdata1 & rdata2), ~(e1 & e2));
        end

        // Randomized traffic, narrow address range to provoke bypass/collisions
        for (int n = 0; n < 3000; n++) begin
            logic narrow;
            narrow = ($urandom_range(0, 3) != 0);
            we     = $urandom_range(0, 1);
            waddr  = narrow ? 5'($urandom_range(0, 5)) : 5'($urandom);
            wdata  = $urandom;
            re1    = ($urandom_range(0, 3) != 0);
            raddr1 = narrow ? 5'($urandom_range(0, 5)) : 5'($urandom);
            re2    = ($urandom_range(0, 3) != 0);
            raddr2 = narrow ? 5'($urandom_range(0, 5)) : 5'($urandom);
            if (n % 400 == 200) begin
                #2 rst = 1'b1;
                #1;
                check("rand_async_rst_p1", rdata1, 32'h0);
                check("rand_async_rst_p2", rdata2, 32'h0);
                #1 rst = 1'b0;
            end
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
